axi2apb_rd_txn_buffer: RTL and testbench

- Parametrised read-side transaction buffer for the AXI2APB bridge, between the AXI slave read channels (AR/R) and the APB master FSM.
- Queues up to ADDR_DEPTH AR requests and expands each INCR burst into per-beat APB read requests.
- Collects APB responses into a DATA_DEPTH data FIFO and returns them as AXI R beats with correct RID, RRESP and RLAST.
- Successor to the single-FIFO bridgebuffer: generalised depths, multiple outstanding bursts, and burst/error handling.

---
 rtl/axi2apb_rd_txn_buffer_if.sv | 43 ++++
 rtl/axi2apb_rd_txn_buffer.sv | 198 +++++++++++++++++++
 tb/tb_axi2apb_rd_txn_buffer.sv | 345 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi2apb_rd_txn_buffer_if.sv
// rtl/axi2apb_rd_txn_buffer_if.sv - AXI AR/R and APB request/response bundle for the read txn buffer
interface axi2apb_rd_txn_buffer_if #(
  parameter int ID_WIDTH   = 1,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ID_WIDTH-1:0]   s_arid;
  logic [ADDR_WIDTH-1:0] s_araddr;
  logic [7:0]            s_arlen;
  logic [2:0]            s_arsize;
  logic                  s_arvalid;
  logic                  s_arready;
  logic [ID_WIDTH-1:0]   s_rid;
  logic [DATA_WIDTH-1:0] s_rdata;
  logic [1:0]            s_rresp;
  logic                  s_rlast;
  logic                  s_rvalid;
  logic                  s_rready;
  logic                  apb_req_valid;
  logic [ADDR_WIDTH-1:0] apb_req_addr;
  logic                  apb_req_ready;
  logic                  apb_rsp_valid;
  logic [DATA_WIDTH-1:0] apb_rsp_data;
  logic                  apb_rsp_err;

  modport slave (
    input  s_arid, s_araddr, s_arlen, s_arsize, s_arvalid,
    output s_arready,
    output s_rid, s_rdata, s_rresp, s_rlast, s_rvalid,
    input  s_rready,
    output apb_req_valid, apb_req_addr,
    input  apb_req_ready, apb_rsp_valid, apb_rsp_data, apb_rsp_err
  );

  modport master (
    output s_arid, s_araddr, s_arlen, s_arsize, s_arvalid,
    input  s_arready,
    input  s_rid, s_rdata, s_rresp, s_rlast, s_rvalid,
    output s_rready,
    input  apb_req_valid, apb_req_addr,
    output apb_req_ready, apb_rsp_valid, apb_rsp_data, apb_rsp_err
  );
endinterface

// File: rtl/axi2apb_rd_txn_buffer.sv
// rtl/axi2apb_rd_txn_buffer.sv - AR queue, INCR beat expander and R data FIFO for the AXI2APB read path
module axi2apb_rd_txn_buffer #(
  parameter int ID_WIDTH   = 1,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_DEPTH = 4,
  parameter int DATA_DEPTH = 8
) (
  input logic clk,
  input logic rst,
  axi2apb_rd_txn_buffer_if.slave bus
);
  localparam int AQ_AW = $clog2(ADDR_DEPTH);
  localparam int DQ_AW = $clog2(DATA_DEPTH);
  localparam logic [AQ_AW:0] AQ_FULL = (AQ_AW+1)'(ADDR_DEPTH);
  localparam logic [DQ_AW:0] DQ_FULL = (DQ_AW+1)'(DATA_DEPTH);
  localparam logic [2:0] MAX_SIZE = 3'($clog2(DATA_WIDTH/8));

  typedef enum logic [1:0] {R_IDLE, R_ISSUE, R_WAIT} state_t;

  state_t state, state_n;
  logic   rdy_en;

  logic [ID_WIDTH-1:0]   aq_id   [ADDR_DEPTH];
  logic [ADDR_WIDTH-1:0] aq_addr [ADDR_DEPTH];
  logic [7:0]            aq_len  [ADDR_DEPTH];
  logic [2:0]            aq_size [ADDR_DEPTH];
  logic [AQ_AW-1:0]      aq_wr_ptr, aq_rd_ptr;
  logic [AQ_AW:0]        aq_count;
  logic                  aq_full, aq_empty, aq_push, aq_pop, ar_fire;

  logic [ID_WIDTH-1:0]   dq_id   [DATA_DEPTH];
  logic [DATA_WIDTH-1:0] dq_data [DATA_DEPTH];
  logic [1:0]            dq_resp [DATA_DEPTH];
  logic                  dq_last [DATA_DEPTH];
  logic [DQ_AW-1:0]      dq_wr_ptr, dq_rd_ptr;
  logic [DQ_AW:0]        dq_count;
  logic                  dq_empty, dq_push, dq_pop, credit;

  logic [ID_WIDTH-1:0]   cur_id;
  logic [ADDR_WIDTH-1:0] cur_addr, addr_incr;
  logic [7:0]            cur_len, beat_cnt;
  logic [2:0]            cur_size, eff_size;
  logic                  is_last, load_head, load_in, advance, req_valid;
  logic [1:0]            rsp_code;

  // AR ready stays low until the first clock after reset release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdy_en <= 1'b0;
    else     rdy_en <= 1'b1;
  end

  assign aq_full        = (aq_count == AQ_FULL);
  assign aq_empty       = (aq_count == '0);
  assign bus.s_arready  = rdy_en && !aq_full;
  assign ar_fire        = bus.s_arvalid && bus.s_arready;
  assign aq_push        = ar_fire && !load_in;

  assign dq_empty       = (dq_count == '0);
  assign credit         = (dq_count != DQ_FULL);
  assign dq_pop         = !dq_empty && bus.s_rready;

  assign eff_size  = (cur_size > MAX_SIZE) ? MAX_SIZE : cur_size;
  assign addr_incr = {{(ADDR_WIDTH-1){1'b0}}, 1'b1} << eff_size;
  assign is_last   = (beat_cnt == cur_len);
  assign rsp_code  = bus.apb_rsp_err ? 2'b10 : 2'b00;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= R_IDLE;
    else     state <= state_n;
  end

  // An AR arriving at an empty idle block is loaded straight into the beat
  // registers so the first APB request follows the handshake by one cycle.
  always_comb begin
    state_n   = state;
    aq_pop    = 1'b0;
    load_head = 1'b0;
    load_in   = 1'b0;
    advance   = 1'b0;
    dq_push   = 1'b0;
    req_valid = 1'b0;
    case (state)
      R_IDLE: begin
        if (credit) begin
          if (!aq_empty) begin
            aq_pop    = 1'b1;
            load_head = 1'b1;
            state_n   = R_ISSUE;
          end else if (ar_fire) begin
            load_in = 1'b1;
            state_n = R_ISSUE;
          end
        end
      end
      R_ISSUE: begin
        req_valid = credit;
        if (credit && bus.apb_req_ready) state_n = R_WAIT;
      end
      R_WAIT: begin
        if (bus.apb_rsp_valid) begin
          dq_push = 1'b1;
          if (is_last) begin
            state_n = R_IDLE;
          end else begin
            advance = 1'b1;
            state_n = R_ISSUE;
          end
        end
      end
      default: state_n = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aq_wr_ptr <= '0;
      aq_rd_ptr <= '0;
      aq_count  <= '0;
    end else begin
      if (aq_push) aq_wr_ptr <= aq_wr_ptr + AQ_AW'(1);
      if (aq_pop)  aq_rd_ptr <= aq_rd_ptr + AQ_AW'(1);
      case ({aq_push, aq_pop})
        2'b10:   aq_count <= aq_count + (AQ_AW+1)'(1);
        2'b01:   aq_count <= aq_count - (AQ_AW+1)'(1);
        default: aq_count <= aq_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (aq_push) begin
      aq_id[aq_wr_ptr]   <= bus.s_arid;
      aq_addr[aq_wr_ptr] <= bus.s_araddr;
      aq_len[aq_wr_ptr]  <= bus.s_arlen;
      aq_size[aq_wr_ptr] <= bus.s_arsize;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_id   <= '0;
      cur_addr <= '0;
      cur_len  <= '0;
      cur_size <= '0;
      beat_cnt <= '0;
    end else if (load_head) begin
      cur_id   <= aq_id[aq_rd_ptr];
      cur_addr <= aq_addr[aq_rd_ptr];
      cur_len  <= aq_len[aq_rd_ptr];
      cur_size <= aq_size[aq_rd_ptr];
      beat_cnt <= '0;
    end else if (load_in) begin
      cur_id   <= bus.s_arid;
      cur_addr <= bus.s_araddr;
      cur_len  <= bus.s_arlen;
      cur_size <= bus.s_arsize;
      beat_cnt <= '0;
    end else if (advance) begin
      cur_addr <= cur_addr + addr_incr;
      beat_cnt <= beat_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dq_wr_ptr <= '0;
      dq_rd_ptr <= '0;
      dq_count  <= '0;
    end else begin
      if (dq_push) dq_wr_ptr <= dq_wr_ptr + DQ_AW'(1);
      if (dq_pop)  dq_rd_ptr <= dq_rd_ptr + DQ_AW'(1);
      case ({dq_push, dq_pop})
        2'b10:   dq_count <= dq_count + (DQ_AW+1)'(1);
        2'b01:   dq_count <= dq_count - (DQ_AW+1)'(1);
        default: dq_count <= dq_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (dq_push) begin
      dq_id[dq_wr_ptr]   <= cur_id;
      dq_data[dq_wr_ptr] <= bus.apb_rsp_data;
      dq_resp[dq_wr_ptr] <= rsp_code;
      dq_last[dq_wr_ptr] <= is_last;
    end
  end

  // Payload is forced to zero when empty so nothing stale is visible after reset.
  assign bus.s_rvalid      = !dq_empty;
  assign bus.s_rid         = dq_empty ? '0 : dq_id[dq_rd_ptr];
  assign bus.s_rdata       = dq_empty ? '0 : dq_data[dq_rd_ptr];
  assign bus.s_rresp       = dq_empty ? 2'b00 : dq_resp[dq_rd_ptr];
  assign bus.s_rlast       = dq_empty ? 1'b0 : dq_last[dq_rd_ptr];
  assign bus.apb_req_valid = req_valid;
  assign bus.apb_req_addr  = cur_addr;
endmodule

// File: tb/tb_axi2apb_rd_txn_buffer.sv
// tb/tb_axi2apb_rd_txn_buffer.sv - scoreboard bench for the AXI2APB read transaction buffer
module tb_axi2apb_rd_txn_buffer;
  localparam int IDW = 1;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam logic [31:0] DATA_KEY = 32'hDEADAEEF;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [DW-1:0]  data;
    logic [1:0]     resp;
    logic           last;
  } rbeat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi2apb_rd_txn_buffer_if #(.ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  axi2apb_rd_txn_buffer #(
    .ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ADDR_DEPTH(4), .DATA_DEPTH(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  rbeat_t        rq[$];
  logic [AW-1:0] aq[$];
  int            pass_cnt = 0;
  int            check_cnt = 0;
  int            r_seen = 0;
  int            apb_req_cnt = 0;
  logic          rr_en = 1'b1;
  logic          apb_stall = 1'b0;
  logic          stray_req = 1'b0;
  logic [AW-1:0] err_addr = 32'h0000_0001;

  // R channel monitor: pops the scoreboard on every handshake.
  initial begin
    rbeat_t got, exp;
    forever begin
      @(negedge clk);
      bus.s_rready = rr_en;
      if (!rst && bus.s_rvalid && bus.s_rready) begin
        got = {bus.s_rid, bus.s_rdata, bus.s_rresp, bus.s_rlast};
        r_seen++;
        check_cnt++;
        if (rq.size() == 0) begin
          $display("FAIL r_unexpected: got %h required no beat", got);
        end else begin
          exp = rq.pop_front();
          if (got !== exp) $display("FAIL r_beat: got %h required %h", got, exp);
          else pass_cnt++;
        end
      end
    end
  end

  // APB FSM model: one request at a time, response two cycles after the handshake.
  initial begin
    logic [AW-1:0] a, exp;
    forever begin
      @(negedge clk);
      bus.apb_rsp_valid = 1'b0;
      bus.apb_rsp_err   = 1'b0;
      if (!rst && !apb_stall && bus.apb_req_valid) begin
        a = bus.apb_req_addr;
        bus.apb_req_ready = 1'b1;
        @(negedge clk);
        bus.apb_req_ready = 1'b0;
        if (!rst) begin
          apb_req_cnt++;
          check_cnt++;
          if (aq.size() == 0) begin
            $display("FAIL apb_unexpected: got addr %h required no request", a);
          end else begin
            exp = aq.pop_front();
            if (a !== exp) $display("FAIL apb_addr: got %h required %h", a, exp);
            else pass_cnt++;
          end
          repeat (2) @(negedge clk);
          if (!rst) begin
            bus.apb_rsp_valid = 1'b1;
            bus.apb_rsp_data  = a ^ DATA_KEY;
            bus.apb_rsp_err   = (a == err_addr);
          end
        end
      end else if (stray_req) begin
        bus.apb_rsp_valid = 1'b1;
        bus.apb_rsp_data  = 32'hBAD0BAD0;
        stray_req = 1'b0;
      end
    end
  end

  function automatic void push_expect(input logic [IDW-1:0] id, input logic [AW-1:0] addr,
                                      input logic [7:0] len, input logic [2:0] size);
    logic [AW-1:0] a;
    logic [2:0]    eff;
    rbeat_t        b;
    a   = addr;
    eff = (size > 3'd2) ? 3'd2 : size;
    for (int i = 0; i <= int'(len); i++) begin
      aq.push_back(a);
      b.id   = id;
      b.data = a ^ DATA_KEY;
      b.resp = (a == err_addr) ? 2'b10 : 2'b00;
      b.last = (i == int'(len));
      rq.push_back(b);
      a = a + (32'd1 << eff);
    end
  endfunction

  task automatic send_ar(input logic [IDW-1:0] id, input logic [AW-1:0] addr,
                         input logic [7:0] len, input logic [2:0] size);
    bit ok;
    ok = 1'b0;
    bus.s_arid = id; bus.s_araddr = addr; bus.s_arlen = len; bus.s_arsize = size;
    bus.s_arvalid = 1'b1;
    for (int c = 0; c < 400; c++) begin
      if (bus.s_arready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (ok) push_expect(id, addr, len, size);
    @(negedge clk);
    bus.s_arvalid = 1'b0;
    check_cnt++;
    if (!ok) $display("FAIL ar_accept: got arready=0 for 400 cycles required 1 (addr %h)", addr);
    else pass_cnt++;
  endtask

  task automatic wait_drain(input string name);
    int c;
    for (c = 0; c < 3000; c++) begin
      if (rq.size() == 0 && aq.size() == 0) break;
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
    check_cnt++;
    if (rq.size() != 0 || aq.size() != 0)
      $display("FAIL %s_drain: got %0d beats %0d reqs pending required 0", name, rq.size(), aq.size());
    else pass_cnt++;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    check_cnt++;
    if ({bus.s_arready, bus.s_rvalid, bus.apb_req_valid, bus.s_rid, bus.s_rdata,
         bus.s_rresp, bus.s_rlast, bus.apb_req_addr} !== '0)
      $display("FAIL reset_outputs: got ar=%b rv=%b qv=%b rdata=%h qaddr=%h required all 0",
               bus.s_arready, bus.s_rvalid, bus.apb_req_valid, bus.s_rdata, bus.apb_req_addr);
    else pass_cnt++;
    rst = 1'b0;
    @(negedge clk);
    check_cnt++;
    if ({bus.s_arready, bus.s_rvalid, bus.apb_req_valid} !== 3'b100)
      $display("FAIL reset_release: got ar/rv/qv=%b%b%b required 100",
               bus.s_arready, bus.s_rvalid, bus.apb_req_valid);
    else pass_cnt++;
  endtask

  task automatic test_single_beat();
    int rs;
    rs = r_seen;
    send_ar(1'b1, 32'h0000_1000, 8'd0, 3'd2);
    check_cnt++;
    if (bus.apb_req_valid !== 1'b1 || bus.apb_req_addr !== 32'h0000_1000)
      $display("FAIL single_latency: got qv=%b qaddr=%h required 1 00001000",
               bus.apb_req_valid, bus.apb_req_addr);
    else pass_cnt++;
    wait_drain("single");
    check_cnt++;
    if (r_seen - rs != 1) $display("FAIL single_count: got %0d beats required 1", r_seen - rs);
    else pass_cnt++;
  endtask

  task automatic test_incr_burst();
    int rs;
    rs = r_seen;
    send_ar(1'b0, 32'h0000_2000, 8'd3, 3'd2);
    wait_drain("incr");
    check_cnt++;
    if (r_seen - rs != 4) $display("FAIL incr_count: got %0d beats required 4", r_seen - rs);
    else pass_cnt++;
  endtask

  task automatic test_size_and_wrap();
    int rs;
    rs = r_seen;
    send_ar(1'b1, 32'hFFFF_FFFC, 8'd1, 3'd2);
    send_ar(1'b0, 32'h0000_5000, 8'd1, 3'd3);
    send_ar(1'b1, 32'h0000_6001, 8'd2, 3'd0);
    wait_drain("wrap");
    check_cnt++;
    if (r_seen - rs != 7) $display("FAIL wrap_count: got %0d beats required 7", r_seen - rs);
    else pass_cnt++;
  endtask

  task automatic test_error();
    int rs;
    rs = r_seen;
    err_addr = 32'h0000_4004;
    send_ar(1'b1, 32'h0000_4000, 8'd2, 3'd2);
    wait_drain("error");
    err_addr = 32'h0000_0001;
    check_cnt++;
    if (r_seen - rs != 3) $display("FAIL error_count: got %0d beats required 3", r_seen - rs);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    int rs, rc;
    rs = r_seen;
    rc = apb_req_cnt;
    rr_en = 1'b0;
    send_ar(1'b0, 32'h0000_3000, 8'd15, 3'd2);
    repeat (120) @(negedge clk);
    check_cnt++;
    if (apb_req_cnt - rc != 8) $display("FAIL bp_req_count: got %0d required 8", apb_req_cnt - rc);
    else pass_cnt++;
    check_cnt++;
    if (bus.apb_req_valid !== 1'b0 || bus.s_rvalid !== 1'b1 || r_seen != rs)
      $display("FAIL bp_hold: got qv=%b rv=%b beats=%0d required 0 1 0",
               bus.apb_req_valid, bus.s_rvalid, r_seen - rs);
    else pass_cnt++;
    rr_en = 1'b1;
    wait_drain("bp");
    check_cnt++;
    if (r_seen - rs != 16) $display("FAIL bp_count: got %0d beats required 16", r_seen - rs);
    else pass_cnt++;
  endtask

  task automatic test_queue_full();
    int rs;
    bit ok, leaked;
    rs = r_seen;
    apb_stall = 1'b1;
    send_ar(1'b0, 32'h0000_7000, 8'd0, 3'd2);
    repeat (2) @(negedge clk);
    for (int k = 1; k <= 4; k++) begin
      bus.s_arid = IDW'(k); bus.s_araddr = 32'h0000_7000 + 32'(k * 16);
      bus.s_arlen = 8'd0; bus.s_arsize = 3'd2; bus.s_arvalid = 1'b1;
      check_cnt++;
      if (bus.s_arready !== 1'b1) $display("FAIL qfull_push%0d: got arready=0 required 1", k);
      else begin pass_cnt++; push_expect(IDW'(k), bus.s_araddr, 8'd0, 3'd2); end
      @(negedge clk);
    end
    bus.s_arid = 1'b1; bus.s_araddr = 32'h0000_7050; bus.s_arvalid = 1'b1;
    leaked = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (bus.s_arready !== 1'b0) leaked = 1'b1;
      @(negedge clk);
    end
    check_cnt++;
    if (leaked) $display("FAIL qfull_block: got arready=1 while full required 0");
    else pass_cnt++;
    apb_stall = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (bus.s_arready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (ok) push_expect(1'b1, 32'h0000_7050, 8'd0, 3'd2);
    @(negedge clk);
    bus.s_arvalid = 1'b0;
    check_cnt++;
    if (!ok) $display("FAIL qfull_fifth: got arready=0 after stall release required 1");
    else pass_cnt++;
    wait_drain("qfull");
    check_cnt++;
    if (r_seen - rs != 6) $display("FAIL qfull_count: got %0d beats required 6", r_seen - rs);
    else pass_cnt++;
  endtask

  task automatic test_stray_rsp();
    int rs;
    rs = r_seen;
    stray_req = 1'b1;
    repeat (6) @(negedge clk);
    check_cnt++;
    if (bus.s_rvalid !== 1'b0 || r_seen != rs)
      $display("FAIL stray_rsp: got rv=%b beats=%0d required 0 0", bus.s_rvalid, r_seen - rs);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_burst();
    int rs, rc;
    bit hit;
    rc = apb_req_cnt;
    send_ar(1'b0, 32'h0000_8000, 8'd7, 3'd2);
    hit = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (apb_req_cnt >= rc + 3) begin hit = 1'b1; break; end
      @(negedge clk);
    end
    check_cnt++;
    if (!hit) $display("FAIL midrst_progress: got %0d reqs required 3", apb_req_cnt - rc);
    else pass_cnt++;
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check_cnt++;
    if ({bus.s_arready, bus.s_rvalid, bus.apb_req_valid, bus.s_rid, bus.s_rdata,
         bus.s_rresp, bus.s_rlast, bus.apb_req_addr} !== '0)
      $display("FAIL midrst_outputs: got ar=%b rv=%b qv=%b rdata=%h qaddr=%h required all 0",
               bus.s_arready, bus.s_rvalid, bus.apb_req_valid, bus.s_rdata, bus.apb_req_addr);
    else pass_cnt++;
    repeat (3) @(negedge clk);
    rq.delete();
    aq.delete();
    rst = 1'b0;
    rs = r_seen;
    repeat (20) @(negedge clk);
    check_cnt++;
    if (bus.s_rvalid !== 1'b0 || r_seen != rs || bus.apb_req_valid !== 1'b0)
      $display("FAIL midrst_stale: got rv=%b qv=%b beats=%0d required 0 0 0",
               bus.s_rvalid, bus.apb_req_valid, r_seen - rs);
    else pass_cnt++;
    send_ar(1'b1, 32'h0000_9000, 8'd1, 3'd2);
    wait_drain("midrst");
    check_cnt++;
    if (r_seen - rs != 2) $display("FAIL midrst_count: got %0d beats required 2", r_seen - rs);
    else pass_cnt++;
  endtask

  initial begin
    bus.s_arid = '0; bus.s_araddr = '0; bus.s_arlen = '0; bus.s_arsize = '0;
    bus.s_arvalid = 1'b0; bus.s_rready = 1'b0;
    bus.apb_req_ready = 1'b0; bus.apb_rsp_valid = 1'b0;
    bus.apb_rsp_data = '0; bus.apb_rsp_err = 1'b0;
    test_reset();
    test_single_beat();
    test_incr_burst();
    test_size_and_wrap();
    test_error();
    test_backpressure();
    test_queue_full();
    test_stray_rsp();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end
endmodule
